// File: rtl/serial_capture_pkg.sv
// Shared definitions for the serial capture block: state encoding and default word width.
package serial_capture_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } captureState_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in shift register; MSB_FIRST selects whether the first bit ends up in the top or bottom bit.
module serial_shift_reg
    import serial_capture_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             d_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (shift_en) begin
            q <= MSB_FIRST ? {q[WIDTH-2:0], d_in} : {d_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_capture.sv
// Frames a qualified serial bit stream into WIDTH-bit words with a single-entry output slot.
//   state | meaning
//   IDLE  | waiting for start; bit_en and d_in ignored
//   SHIFT | frame in progress; bits sampled on bit_en until WIDTH collected
module serial_capture
    import serial_capture_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             bit_en,
    input  logic             start,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    captureState_t    state, nextState;
    logic [CNT_W-1:0] bitCount;
    logic             shiftEn;
    logic             wordDone;
    logic [WIDTH-1:0] shiftQ;
    logic [WIDTH-1:0] fullWord;

    serial_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) shiftReg (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .shift_en(shiftEn),
        .d_in    (d_in),
        .q       (shiftQ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // start wins over bit_en in both states, so a completing bit coincident with start is lost.
    always_comb begin
        nextState = state;
        shiftEn   = 1'b0;
        wordDone  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (!start && bit_en) begin
                    shiftEn = 1'b1;
                    if (bitCount == LAST_BIT) begin
                        wordDone  = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start || wordDone) begin
            bitCount <= '0;
        end else if (shiftEn) begin
            bitCount <= bitCount + 1'b1;
        end
    end

    // The last bit is still on d_in at the completing edge, so fold it in here.
    always_comb begin
        fullWord = MSB_FIRST ? {shiftQ[WIDTH-2:0], d_in} : {d_in, shiftQ[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (wordDone && (!word_valid || word_ready)) begin
            word_out   <= fullWord;
            word_valid <= 1'b1;
        end else if (wordDone) begin
            overflow   <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_capture.sv
// Randomized and directed bench for serial_capture; MSB-first and LSB-first instances share stimulus.
module tb_serial_capture;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         d_in = 1'b0;
    logic         bit_en = 1'b0;
    logic         start = 1'b0;
    logic         word_ready = 1'b0;
    logic [W-1:0] wordOutM, wordOutL;
    logic         validM, validL, busyM, busyL, ovM, ovL;

    always #5 clk = ~clk;

    serial_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk       (clk),
        .reset     (reset),
        .d_in      (d_in),
        .bit_en    (bit_en),
        .start     (start),
        .word_ready(word_ready),
        .word_out  (wordOutM),
        .word_valid(validM),
        .busy      (busyM),
        .overflow  (ovM)
    );

    serial_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk       (clk),
        .reset     (reset),
        .d_in      (d_in),
        .bit_en    (bit_en),
        .start     (start),
        .word_ready(word_ready),
        .word_out  (wordOutL),
        .word_valid(validL),
        .busy      (busyL),
        .overflow  (ovL)
    );

    int passCnt = 0;
    int totalCnt = 0;

    logic [W-1:0] expMsb[$];
    logic [W-1:0] expLsb[$];
    bit           bits[$];
    bit           mBusy = 1'b0;
    bit           mValid = 1'b0;
    bit           mOv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: collect the sampled bits of a frame, build the word arithmetically once WIDTH are in.
    task automatic modelEdge(input bit r, input bit st, input bit be, input bit d, input bit rdy);
        bit             completed;
        logic [W-1:0]   wm, wl;
        completed = 1'b0;
        wm = '0;
        wl = '0;
        if (r) begin
            mBusy = 1'b0;
            mValid = 1'b0;
            mOv = 1'b0;
            bits.delete();
            expMsb.delete();
            expLsb.delete();
        end else begin
            if (st) begin
                mBusy = 1'b1;
                bits.delete();
            end else if (mBusy && be) begin
                bits.push_back(d);
                if (bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm = wm | (W'(bits[i]) << (W - 1 - i));
                        wl = wl | (W'(bits[i]) << i);
                    end
                    completed = 1'b1;
                    mBusy = 1'b0;
                    bits.delete();
                end
            end
            if (completed) begin
                if (!mValid || rdy) begin
                    expMsb.push_back(wm);
                    expLsb.push_back(wl);
                    mValid = 1'b1;
                end else begin
                    mOv = 1'b1;
                end
            end else if (mValid && rdy) begin
                mValid = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit st, input bit be, input bit d, input bit rdy);
        @(negedge clk);
        reset = r;
        start = st;
        bit_en = be;
        d_in = d;
        word_ready = rdy;
        modelEdge(r, st, be, d, rdy);
        @(posedge clk);
        #1;
        check("busy msb", busyM, mBusy);
        check("busy lsb", busyL, mBusy);
        check("valid msb", validM, mValid);
        check("valid lsb", validL, mValid);
        check("overflow msb", ovM, mOv);
        check("overflow lsb", ovL, mOv);
        if (mValid) begin
            if (expMsb.size() == 0 || expLsb.size() == 0) check("slot model empty", 1, 0);
            else begin
                check("held word msb", wordOutM, expMsb[0]);
                check("held word lsb", wordOutL, expLsb[0]);
            end
        end
        if (r) begin
            check("reset word msb", wordOutM, 0);
            check("reset word lsb", wordOutL, 0);
        end
    endtask

    task automatic frame(input logic [W-1:0] w, input bit gaps, input bit rdy, output int busyCycles);
        busyCycles = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, rdy);
        if (busyM) busyCycles++;
        for (int i = 0; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, w[W-1-i], rdy);
            if (busyM) busyCycles++;
            if (gaps && i < W - 1) begin
                step(1'b0, 1'b0, 1'b0, ~w[W-1-i], rdy);
                if (busyM) busyCycles++;
            end
        end
    endtask

    // Monitor: every handshake pops the oldest expected word and compares what the DUT presents.
    always @(posedge clk) begin
        if (!reset && word_ready && validM) begin
            if (expMsb.size() == 0) check("unexpected word msb", 1, 0);
            else check("word msb", wordOutM, expMsb.pop_front());
        end
        if (!reset && word_ready && validL) begin
            if (expLsb.size() == 0) check("unexpected word lsb", 1, 0);
            else check("word lsb", wordOutL, expLsb.pop_front());
        end
    end

    initial begin
        int bc;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        frame(8'hB2, 1'b0, 1'b1, bc);
        check("b2 word msb", wordOutM, 8'hB2);
        check("b2 word lsb", wordOutL, 8'h4D);
        check("b2 busy cycles", bc, 8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2 valid one cycle", validM, 0);

        frame(8'hB2, 1'b0, 1'b0, bc);
        check("held valid", validM, 1);
        frame(8'hFF, 1'b0, 1'b0, bc);
        check("overflow set", ovM, 1);
        check("overflow keeps word", wordOutM, 8'hB2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("overflow drain valid", validM, 0);
        check("overflow sticky", ovM, 1);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        frame(8'h01, 1'b0, 1'b1, bc);
        check("restart word", wordOutM, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("reset busy", busyM, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("no word after reset", validM, 0);

        frame(8'hA5, 1'b1, 1'b1, bc);
        check("gap word msb", wordOutM, 8'hA5);
        check("gap word lsb", wordOutL, 8'hA5);
        check("gap valid", validM, 1);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pending words msb", expMsb.size(), 0);
        check("pending words lsb", expLsb.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
